// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared constants and FSM state type for the USB transmit encoder
//   PID_*           : handshake / data PID bytes
//   SYNC_BYTE       : SYNC pattern, sent LSB first
//   CRC16_POLY/INIT : CRC16 generator polynomial and seed
//   tx_state_t      : transmit FSM states
package usb_tx_pkg;
    localparam logic [7:0]  PID_ACK    = 8'hD2;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_PAYLOAD,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;
endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: serial CRC16 (x^16+x^15+x^2+1), one data bit per enabled cycle
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : reseed register with CRC16_INIT
//   shift_en   : absorb bit_in this cycle
//   bit_in     : serial data bit
//   crc        : current CRC register
module usb_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        shift_en,
    input  logic        bit_in,
    output logic [15:0] crc
);
    logic [15:0] crc_q, crc_d;
    always_comb begin
        crc_d = clear    ? CRC16_INIT :
                shift_en ? ({crc_q[14:0], 1'b0} ^ ((bit_in ^ crc_q[15]) ? CRC16_POLY : 16'h0000)) :
                           crc_q;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) crc_q <= CRC16_INIT;
        else        crc_q <= crc_d;
    end
    assign crc = crc_q;
endmodule

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB full-speed ACK/NAK/DATA0 transmitter (SYNC, PID, payload, CRC16, bit stuffing, NRZI, EOP)
//   clk, n_rst              : clock, asynchronous active-low reset
//   transmit_ack/nack       : single-cycle handshake requests (nack wins over ack)
//   host_ready              : single-cycle DATA0 request, captures {7'b0, hash_found} and nonce
//   d_plus, d_minus         : registered USB line pair, J when idle
//   tx_busy, tx_done        : packet in flight / one-cycle completion pulse
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        transmit_ack,
    input  logic        transmit_nack,
    input  logic        host_ready,
    input  logic [31:0] nonce,
    input  logic        hash_found,
    output logic        d_plus,
    output logic        d_minus,
    output logic        tx_busy,
    output logic        tx_done
);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    tx_state_t     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d, byte_cnt_q, byte_cnt_d, ones_q, ones_d;
    logic [7:0]    pid_q, pid_d;
    logic [39:0]   payload_q, payload_d;
    logic          d_plus_q, d_plus_d, d_minus_q, d_minus_d;
    logic          tx_busy_q, tx_busy_d, tx_done_q, tx_done_d;
    logic          tick, raw, field_end, crc_clear, crc_shift;
    logic [15:0]   crc;

    usb_crc16 u_crc (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (crc_clear),
        .shift_en (crc_shift),
        .bit_in   (payload_q[0]),
        .crc      (crc)
    );

    // In IDLE a request is itself a bit boundary, so the first SYNC bit appears one cycle later.
    assign tick = (state_q == ST_IDLE) ? (transmit_nack | transmit_ack | host_ready)
                                       : (div_q == DW'(CLKS_PER_BIT - 1));
    // CRC goes out complemented, register bit 15 first.
    assign raw = (state_q == ST_SYNC)    ? SYNC_BYTE[bit_cnt_q] :
                 (state_q == ST_PID)     ? pid_q[bit_cnt_q] :
                 (state_q == ST_PAYLOAD) ? payload_q[0] :
                                           ~crc[~{byte_cnt_q[0], bit_cnt_q}];
    assign field_end = (bit_cnt_q == 3'd7) &&
                       ((state_q == ST_PAYLOAD) ? (byte_cnt_q == 3'd4) :
                        (state_q == ST_CRC)     ? (byte_cnt_q == 3'd1) : 1'b1);

    always_comb begin
        state_d    = state_q;
        div_d      = (state_q == ST_IDLE || tick) ? '0 : div_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ones_d     = ones_q;
        pid_d      = pid_q;
        payload_d  = payload_q;
        d_plus_d   = d_plus_q;
        d_minus_d  = d_minus_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        crc_clear  = 1'b0;
        crc_shift  = 1'b0;
        if (tick) begin
            if (state_q == ST_IDLE) begin
                // First SYNC bit is a 0, so the line moves J -> K on acceptance.
                state_d    = ST_SYNC;
                bit_cnt_d  = 3'd1;
                byte_cnt_d = '0;
                ones_d     = '0;
                pid_d      = transmit_nack ? PID_NAK : transmit_ack ? PID_ACK : PID_DATA0;
                payload_d  = (transmit_nack | transmit_ack) ? payload_q : {nonce, 7'b0, hash_found};
                crc_clear  = 1'b1;
                tx_busy_d  = 1'b1;
                d_plus_d   = 1'b0;
                d_minus_d  = 1'b1;
            end else if (ones_q == 3'd6) begin
                // Stuffed 0: the line toggles while shifter, counters and CRC hold.
                ones_d    = '0;
                d_plus_d  = ~d_plus_q;
                d_minus_d = d_plus_q;
            end else if (state_q == ST_EOP_SE0) begin
                ones_d    = '0;
                d_plus_d  = 1'b0;
                d_minus_d = 1'b0;
                bit_cnt_d = (bit_cnt_q == 3'd1) ? 3'd0 : bit_cnt_q + 3'd1;
                state_d   = (bit_cnt_q == 3'd1) ? ST_EOP_J : ST_EOP_SE0;
            end else if (state_q == ST_EOP_J) begin
                // Drive J for one bit time, then return to IDLE on the following boundary.
                d_plus_d  = 1'b1;
                d_minus_d = 1'b0;
                bit_cnt_d = (bit_cnt_q == 3'd1) ? 3'd0 : 3'd1;
                state_d   = (bit_cnt_q == 3'd1) ? ST_IDLE : ST_EOP_J;
                tx_busy_d = (bit_cnt_q != 3'd1);
                tx_done_d = (bit_cnt_q == 3'd1);
            end else begin
                d_plus_d   = raw ? d_plus_q : ~d_plus_q;
                d_minus_d  = raw ? d_minus_q : d_plus_q;
                ones_d     = (raw && state_q != ST_SYNC) ? ones_q + 3'd1 : '0;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                byte_cnt_d = field_end ? '0 : byte_cnt_q + 3'(bit_cnt_q == 3'd7);
                payload_d  = (state_q == ST_PAYLOAD) ? payload_q >> 1 : payload_q;
                crc_shift  = (state_q == ST_PAYLOAD);
                if (field_end)
                    state_d = (state_q == ST_SYNC)    ? ST_PID :
                              (state_q == ST_PID)     ? ((pid_q == PID_DATA0) ? ST_PAYLOAD : ST_EOP_SE0) :
                              (state_q == ST_PAYLOAD) ? ST_CRC : ST_EOP_SE0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            ones_q     <= '0;
            pid_q      <= '0;
            payload_q  <= '0;
            d_plus_q   <= 1'b1;
            d_minus_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ones_q     <= ones_d;
            pid_q      <= pid_d;
            payload_q  <= payload_d;
            d_plus_q   <= d_plus_d;
            d_minus_q  <= d_minus_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign d_plus  = d_plus_q;
    assign d_minus = d_minus_q;
    assign tx_busy = tx_busy_q;
    assign tx_done = tx_done_q;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// tb_usb_tx_encoder: self-checking bench for usb_tx_encoder against a bit-level packet model
module tb_usb_tx_encoder;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        transmit_ack = 1'b0;
    logic        transmit_nack = 1'b0;
    logic        host_ready = 1'b0;
    logic [31:0] nonce = '0;
    logic        hash_found = 1'b0;
    logic        d_plus, d_minus, tx_busy, tx_done;
    int          checks = 0;
    int          failures = 0;
    logic [1:0]  exp_line[$];
    logic [15:0] exp_crc;
    logic [7:0]  exp_pid;
    int          exp_stuffs;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(8)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .transmit_ack  (transmit_ack),
        .transmit_nack (transmit_nack),
        .host_ready    (host_ready),
        .nonce         (nonce),
        .hash_found    (hash_found),
        .d_plus        (d_plus),
        .d_minus       (d_minus),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CRC by polynomial long division: seeding with ones equals inverting the first 16 message bits.
    function automatic logic [15:0] crc_golden(input logic [39:0] p);
        logic        d[56];
        logic [15:0] r;
        for (int i = 0; i < 56; i++) d[i] = (i < 40) ? (p[i] ^ (i < 16)) : 1'b0;
        for (int i = 0; i < 40; i++)
            if (d[i]) begin
                d[i] ^= 1'b1;
                d[i + 1] ^= 1'b1;
                d[i + 14] ^= 1'b1;
                d[i + 16] ^= 1'b1;
            end
        for (int j = 0; j < 16; j++) r[15 - j] = d[40 + j];
        return r;
    endfunction

    function automatic logic [63:0] take(input logic q[$], input int off, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[i] = (off + i < q.size()) ? q[off + i] : 1'bx;
        return v;
    endfunction

    task automatic build_model(input int kind, input logic [39:0] p);
        logic raw[$];
        logic lvl = 1'b1;
        int   ones = 0;
        exp_line.delete();
        exp_stuffs = 0;
        exp_pid = (kind == 0) ? 8'hD2 : (kind == 1) ? 8'h5A : 8'hC3;
        exp_crc = crc_golden(p);
        for (int i = 0; i < 8; i++) raw.push_back(exp_pid[i]);
        if (kind == 2) begin
            for (int i = 0; i < 40; i++) raw.push_back(p[i]);
            for (int i = 0; i < 16; i++) raw.push_back(~exp_crc[15 - i]);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 7) lvl = ~lvl;
            exp_line.push_back({lvl, ~lvl});
        end
        foreach (raw[i]) begin
            if (!raw[i]) lvl = ~lvl;
            exp_line.push_back({lvl, ~lvl});
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                lvl = ~lvl;
                exp_line.push_back({lvl, ~lvl});
                ones = 0;
                exp_stuffs++;
            end
        end
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b10);
    endtask

    // kind: 0 ack, 1 nak, 2 data0, 3 ack+nak, 4 all three; noise = cycle at which ack/host_ready are re-pulsed
    task automatic run_pkt(input string tag, input int kind, input logic [31:0] n, input logic hf, input int noise);
        int          mk = (kind >= 3) ? 1 : kind;
        logic [39:0] p = {n, 7'b0, hf};
        int          cyc = 0;
        int          len = -1;
        int          bad_line = 0;
        int          bad_busy = 0;
        int          bad_idle = 0;
        int          stuffs = 0;
        int          ones = 0;
        logic [1:0]  e;
        logic [1:0]  got[$];
        logic        bits[$];
        logic        prev = 1'b1;
        logic [7:0]  sync_got = '0;
        logic [63:0] crc_exp = '0;
        build_model(mk, p);
        @(negedge clk);
        transmit_ack  = (kind == 0 || kind >= 3);
        transmit_nack = (kind == 1 || kind >= 3);
        host_ready    = (kind == 2 || kind == 4);
        nonce         = n;
        hash_found    = hf;
        @(negedge clk);
        transmit_ack  = 1'b0;
        transmit_nack = 1'b0;
        host_ready    = 1'b0;
        while (len < 0 && cyc < 1200) begin
            if (tx_done) len = cyc;
            else begin
                e = (cyc / 8 < exp_line.size()) ? exp_line[cyc / 8] : 2'b10;
                if ({d_plus, d_minus} !== e) bad_line++;
                if (tx_busy !== 1'b1) bad_busy++;
                if (cyc % 8 == 4) got.push_back({d_plus, d_minus});
                transmit_ack = (cyc == noise);
                host_ready   = (cyc == noise);
                nonce        = $urandom;
                hash_found   = 1'($urandom);
                @(negedge clk);
                cyc++;
            end
        end
        transmit_ack = 1'b0;
        host_ready   = 1'b0;
        chk({tag, ":length"}, 64'(len), 64'(8 * exp_line.size()));
        chk({tag, ":line_bad_cycles"}, 64'(bad_line), 64'd0);
        chk({tag, ":busy_bad_cycles"}, 64'(bad_busy), 64'd0);
        repeat (12) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_busy !== 1'b0 || {d_plus, d_minus} !== 2'b10) bad_idle++;
        end
        chk({tag, ":idle_after"}, 64'(bad_idle), 64'd0);
        for (int k = 0; k < got.size() && got[k] != 2'b00; k++) begin
            logic r;
            r = (got[k][1] == prev);
            prev = got[k][1];
            if (k < 8) sync_got[k] = r;
            else if (ones == 6) begin
                ones = 0;
                stuffs++;
            end else begin
                bits.push_back(r);
                ones = r ? ones + 1 : 0;
            end
        end
        chk({tag, ":sync"}, 64'(sync_got), 64'h80);
        chk({tag, ":pid"}, take(bits, 0, 8), 64'(exp_pid));
        chk({tag, ":decoded_bits"}, 64'(bits.size()), (mk == 2) ? 64'd64 : 64'd8);
        chk({tag, ":stuffed"}, 64'(stuffs), 64'(exp_stuffs));
        if (mk == 2) begin
            for (int j = 0; j < 16; j++) crc_exp[j] = ~exp_crc[15 - j];
            chk({tag, ":payload"}, take(bits, 8, 40), 64'(p));
            chk({tag, ":crc"}, take(bits, 48, 16), crc_exp);
        end
    endtask

    initial begin
        int quiet;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({d_plus, d_minus, tx_busy, tx_done}), 64'b1000);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_state", 64'({d_plus, d_minus, tx_busy, tx_done}), 64'b1000);
        run_pkt("ack", 0, 32'h0, 1'b0, -1);
        run_pkt("nak", 1, 32'h0, 1'b0, -1);
        run_pkt("data_12345678", 2, 32'h12345678, 1'b1, -1);
        run_pkt("data_ffffffff", 2, 32'hFFFFFFFF, 1'b1, -1);
        chk("ffffffff_stuff_min", 64'(exp_stuffs >= 5), 64'd1);
        run_pkt("data_zero", 2, 32'h0, 1'b0, -1);
        run_pkt("ack_nak_same_cycle", 3, 32'h0, 1'b0, 60);
        run_pkt("all_three", 4, 32'hA5A5A5A5, 1'b1, 100);
        @(negedge clk);
        host_ready = 1'b1;
        nonce      = 32'hCAFEF00D;
        hash_found = 1'b1;
        @(negedge clk);
        host_ready = 1'b0;
        repeat (200) @(negedge clk);
        chk("rst_mid:busy_before", 64'(tx_busy), 64'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid:async_lines", 64'({d_plus, d_minus, tx_busy, tx_done}), 64'b1000);
        @(negedge clk);
        n_rst = 1'b1;
        quiet = 0;
        repeat (700) begin
            @(negedge clk);
            if (tx_done !== 1'b0 || tx_busy !== 1'b0) quiet++;
        end
        chk("rst_mid:no_done", 64'(quiet), 64'd0);
        run_pkt("ack_after_rst", 0, 32'h0, 1'b0, -1);
        for (int i = 0; i < 10; i++)
            run_pkt($sformatf("rand%0d", i), int'($urandom_range(0, 4)), $urandom, 1'($urandom),
                    int'($urandom_range(0, 700)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

USB full-speed transmit encoder for the miner's USB endpoint, directly downstream of the packet decoder controller. It turns the controller's single-cycle `transmit_ack`, `transmit_nack` and `host_ready` pulses into complete packets on `d_plus`/`d_minus`: ACK or NAK handshakes, or a DATA0 packet carrying the hash status and nonce. It handles SYNC, PID, payload, CRC16, bit stuffing, NRZI and EOP.

## Interface
- `CLKS_PER_BIT`, default 8: clk cycles per USB bit time (96 MHz clock / 12 Mbps).
- `clk` input 1: system clock.
- `n_rst` input 1: reset, asynchronous, active-low. Clock is clk.
- `transmit_ack` input 1: pulse; send ACK handshake.
- `transmit_nack` input 1: pulse; send NAK handshake.
- `host_ready` input 1: pulse; send DATA0 result packet.
- `nonce` input 32: current nonce, captured at request.
- `hash_found` input 1: hash-found flag, captured at request.
- `d_plus` output 1: USB D+ line.
- `d_minus` output 1: USB D− line.
- `tx_busy` output 1: high while a packet is in flight.
- `tx_done` output 1: one-cycle pulse when a packet completes.

## Operation
- **Reset / idle values.** Reset forces `d_plus=1`, `d_minus=0` (J), `tx_busy=0`, `tx_done=0`, state IDLE, all counters zero.
- **Request sampling.**
  - Requests are sampled only in IDLE.
  - Simultaneous requests resolve by priority: nack > ack > host_ready. Losers are dropped.
  - Requests arriving while busy are dropped, not queued.
- **Capture.** On host_ready, `{7'b0, hash_found}` and `nonce` are captured into a 40-bit payload register. Inputs are ignored after that.
- **State sequence.** IDLE → SYNC → PID → (PAYLOAD → CRC, DATA0 only) → EOP_SE0 → EOP_J → IDLE.
- **Bit order.** All fields go out LSB first.
- **SYNC:** 8'h80, i.e. seven 0s then a 1.
- **PID byte:** ACK 8'hD2, NAK 8'h5A, DATA0 8'hC3.
- **PAYLOAD:**
  - Byte 0 is the status byte.
  - Bytes 1–4 are the nonce, least-significant byte first.
- **CRC16:**
  - Polynomial x^16+x^15+x^2+1 (0x8005), register initialised to 16'hFFFF at PAYLOAD start, fed with payload bits only.
  - The one's complement of the remainder is sent, highest CRC register bit first.
- **Bit stuffing.**
  - Applies from PID through CRC.
  - After six consecutive raw 1s, one 0 is inserted.
  - The data shift, bit counter and CRC update all hold for that stuffed bit.
  - The ones-run counter resets on every 0, including stuffed 0s.
  - SYNC does not count toward the run.
- **NRZI.** A raw 0 toggles the line between J (1/0) and K (0/1); a raw 1 holds it. NRZI state starts at J.
- **EOP.** Two bit times of SE0 (`d_plus=0`, `d_minus=0`), then one bit time of J, then return to IDLE.

## Timing
- **Divider.** A counter runs 0..CLKS_PER_BIT−1. A new line value is driven when the counter reaches 0 and held for CLKS_PER_BIT cycles.
- **Start latency.**
  - Request sampled in cycle N: `tx_busy=1` and the first SYNC bit are driven from cycle N+1.
  - The registered line outputs change only at bit boundaries.
- **Completion.**
  - `tx_done` pulses in the first IDLE cycle after EOP_J ends.
  - `tx_busy` is 0 in that same cycle.
  - A new request is accepted in that cycle.
- **Packet lengths.**
  - ACK/NAK: 19 bit times = 152 cycles with CLKS_PER_BIT=8. No stuffing is possible.
  - DATA0: 8+8+40+16+3 = 75 bit times, plus one bit time per stuffed bit.
- **Reset mid-packet.** Lines return to J asynchronously, the packet is abandoned and `tx_done` is not pulsed.

## Structure
- **Package `usb_tx_pkg`:**
  - PID constants: PID_ACK, PID_NAK, PID_DATA0.
  - SYNC_BYTE.
  - CRC16_POLY and CRC16_INIT.
  - The `tx_state_t` enum.
- **Sub-module `usb_crc16`:** serial CRC with `clear`, `shift_en`, `bit_in` inputs and a `crc[15:0]` output.
- **Main module contents:** FSM, bit divider, bit/byte counters, stuff counter, NRZI register.

## Test plan
- ACK pulse → line sequence per bit time K J K J K J K K, then the PID NRZI, then SE0 SE0 J; `tx_done` 152 cycles after the request.
- NAK pulse → PID field decodes to 8'h5A; no stuffed bits; same 152-cycle length.
- host_ready, nonce=32'h12345678, hash_found=1 → the decoded payload is 01 78 56 34 12, and the CRC field matches the golden model.
- host_ready, nonce=32'hFFFFFFFF, hash_found=1 → 5 stuffed 0s within the payload (after every sixth consecutive 1); CRC still correct; length grows accordingly.
- transmit_ack and transmit_nack in the same cycle → only NAK is sent. An ack pulse during that packet is ignored, giving exactly one `tx_done`.
- Assert n_rst in the middle of the DATA0 payload → J immediately; no `tx_done`; a following ACK request transmits correctly.
